// File: rtl/clk_bringup_seq_if.sv
// Control/status and AD9545 datapath bundle for the clock bring-up sequencer.
// Master drives the inputs; the sequencer (slave) drives the outputs.
interface clk_bringup_seq_if;
  logic        i_start;
  logic        i_sw_ad9545_rst;
  logic        o_ad9545_rst;
  logic        o_clk_chk_en;
  logic        i_clk_chk_in_tolerance;
  logic [31:0] i_clk_chk_count;
  logic [6:0]  i_ad9545_mode_pins;
  logic [6:0]  o_mode_pins;
  logic [31:0] o_last_count;
  logic [2:0]  o_state;
  logic [3:0]  o_attempt;
  logic        o_busy;
  logic        o_locked;
  logic        o_fail;
  logic        o_lock_lost;

  modport master (
    output i_start,
    output i_sw_ad9545_rst,
    output i_clk_chk_in_tolerance,
    output i_clk_chk_count,
    output i_ad9545_mode_pins,
    input  o_ad9545_rst,
    input  o_clk_chk_en,
    input  o_mode_pins,
    input  o_last_count,
    input  o_state,
    input  o_attempt,
    input  o_busy,
    input  o_locked,
    input  o_fail,
    input  o_lock_lost
  );

  modport slave (
    input  i_start,
    input  i_sw_ad9545_rst,
    input  i_clk_chk_in_tolerance,
    input  i_clk_chk_count,
    input  i_ad9545_mode_pins,
    output o_ad9545_rst,
    output o_clk_chk_en,
    output o_mode_pins,
    output o_last_count,
    output o_state,
    output o_attempt,
    output o_busy,
    output o_locked,
    output o_fail,
    output o_lock_lost
  );
endinterface

// File: rtl/clk_bringup_seq.sv
// AD9545 bring-up sequencer: reset pulse, strap capture, clock check with
// bounded retries, and lock monitoring with automatic re-run on loss.
module clk_bringup_seq #(
  parameter int unsigned RST_ASSERT_CYC  = 1000,
  parameter int unsigned RST_WAIT_CYC    = 100000,
  parameter int unsigned CHK_TIMEOUT_CYC = 1000000,
  parameter int unsigned GOOD_CYC        = 16,
  parameter int unsigned LOSS_CYC        = 16,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic              i_apb_clk,
  input  logic              i_apb_rst_n,
  clk_bringup_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RA     = 3'd1,
    S_RW     = 3'd2,
    S_CHK    = 3'd3,
    S_LOCKED = 3'd4,
    S_FAIL   = 3'd5
  } state_e;

  localparam logic [31:0] RA_LD   = 32'(RST_ASSERT_CYC - 1);
  localparam logic [31:0] RW_LD   = 32'(RST_WAIT_CYC - 1);
  localparam logic [31:0] TO_LD   = 32'(CHK_TIMEOUT_CYC - 1);
  localparam logic [31:0] GOOD_N  = 32'(GOOD_CYC);
  localparam logic [31:0] LOSS_N  = 32'(LOSS_CYC);
  localparam logic [3:0]  MAX_ATT = 4'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] run_q, run_d;
  logic [6:0]  pins_q, pins_d;
  logic [31:0] last_q, last_d;
  logic [3:0]  att_q, att_d;
  logic        lost_q, lost_d;
  logic        start_q;
  logic        rst_q, en_q, busy_q, lock_q, fail_q;

  logic        rise;
  logic        tol;
  logic [31:0] run_inc;

  assign rise    = bus.i_start & ~start_q;
  assign tol     = bus.i_clk_chk_in_tolerance;
  assign run_inc = run_q + 32'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    pins_d  = pins_q;
    last_d  = last_q;
    att_d   = att_q;
    lost_d  = lost_q;
    // Dropping the enable aborts from any active state
    if (state_q != S_IDLE && !bus.i_start) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rise) begin
            state_d = S_RA;
            cnt_d   = RA_LD;
            att_d   = 4'd1;
            lost_d  = 1'b0;
          end
        end
        S_RA: begin
          cnt_d = cnt_q - 32'd1;
          if (cnt_q == 32'd0) begin
            pins_d  = bus.i_ad9545_mode_pins;
            state_d = S_RW;
            cnt_d   = RW_LD;
          end
        end
        S_RW: begin
          cnt_d = cnt_q - 32'd1;
          if (cnt_q == 32'd0) begin
            state_d = S_CHK;
            cnt_d   = TO_LD;
            run_d   = 32'd0;
          end
        end
        S_CHK: begin
          cnt_d = cnt_q - 32'd1;
          run_d = tol ? run_inc : 32'd0;
          // A pass on the final timeout cycle wins
          if (tol && run_inc == GOOD_N) begin
            state_d = S_LOCKED;
            run_d   = 32'd0;
            last_d  = bus.i_clk_chk_count;
          end else if (cnt_q == 32'd0) begin
            last_d = bus.i_clk_chk_count;
            if (att_q == MAX_ATT) begin
              state_d = S_FAIL;
            end else begin
              att_d   = att_q + 4'd1;
              state_d = S_RA;
              cnt_d   = RA_LD;
            end
          end
        end
        S_LOCKED: begin
          run_d = tol ? 32'd0 : run_inc;
          if (!tol && run_inc == LOSS_N) begin
            lost_d  = 1'b1;
            att_d   = 4'd1;
            state_d = S_RA;
            cnt_d   = RA_LD;
            run_d   = 32'd0;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
    if (!i_apb_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      run_q   <= '0;
      pins_q  <= '0;
      last_q  <= '0;
      att_q   <= '0;
      lost_q  <= 1'b0;
      start_q <= 1'b0;
      rst_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      lock_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      pins_q  <= pins_d;
      last_q  <= last_d;
      att_q   <= att_d;
      lost_q  <= lost_d;
      start_q <= bus.i_start;
      rst_q   <= (state_d == S_RA);
      en_q    <= (state_d == S_CHK) || (state_d == S_LOCKED);
      busy_q  <= (state_d == S_RA) || (state_d == S_RW) ||
                 (state_d == S_CHK);
      lock_q  <= (state_d == S_LOCKED);
      fail_q  <= (state_d == S_FAIL);
    end
  end

  assign bus.o_ad9545_rst = rst_q | bus.i_sw_ad9545_rst;
  assign bus.o_clk_chk_en = en_q;
  assign bus.o_mode_pins  = pins_q;
  assign bus.o_last_count = last_q;
  assign bus.o_state      = state_q;
  assign bus.o_attempt    = att_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_locked     = lock_q;
  assign bus.o_fail       = fail_q;
  assign bus.o_lock_lost  = lost_q;

endmodule
